// File: rtl/clock_group_pkg.sv
// clock_group_pkg
// Shared definitions for the clock-group reset sequencer:
//   - seq_state_t   : sequencer state encoding
//   - clog2         : ceiling log2 (clog2(1) = 0)
//   - member_width  : width of a member index, never below 1 bit
//   - counter_width : width of the hold/lead delay counter
//   - params_ok     : legality check for the sequencer parameters
package clock_group_pkg;

  typedef enum logic [2:0] {
    BOOT_HOLD = 3'd0,
    BOOT_GAP  = 3'd1,
    IDLE      = 3'd2,
    SOFT_HOLD = 3'd3,
    SOFT_GAP  = 3'd4
  } seq_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned member_width(input int unsigned n_members);
    return (n_members <= 1) ? 1 : clog2(n_members);
  endfunction

  function automatic int unsigned counter_width(input int unsigned hold_cycles,
                                                input int unsigned lead_cycles);
    int unsigned longest;
    longest = (hold_cycles > lead_cycles) ? hold_cycles : lead_cycles;
    return (clog2(longest + 1) < 1) ? 1 : clog2(longest + 1);
  endfunction

  function automatic bit params_ok(input int unsigned n_members,
                                   input int unsigned hold_cycles,
                                   input int unsigned lead_cycles);
    return (n_members >= 1) && (hold_cycles >= 1) && (lead_cycles >= 1);
  endfunction

endpackage

// File: rtl/clock_group_delay_counter.sv
// clock_group_delay_counter
// Loadable down-counter timing the hold and lead phases of the sequencer.
// Ports:
//   clock, reset : sole clock, asynchronous active-high reset (count -> 0)
//   load         : load load_value on the next edge (has priority)
//   load_value   : count to load
//   expire       : count has reached 1, i.e. the timed phase ends this edge
// The count decrements towards zero and stops there; it never wraps.
module clock_group_delay_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
// Drives per-member reset and clock enable for one clock group. After global
// reset, members are brought up one at a time in index order (clock enable
// first, reset released HOLD_CYCLES later, LEAD_CYCLES gap before the next
// member). In IDLE it accepts soft-reset requests for one member, optionally
// cascading to every higher-indexed member.
// Ports:
//   clock, reset         : sole clock, asynchronous active-high reset
//   io_req_valid         : soft-reset request
//   io_req_member        : target member index
//   io_req_ready         : high only in IDLE; valid && ready accepts a request
//   out_member_reset     : per-member reset, active-high
//   out_member_clock_en  : per-member clock enable (never cleared after boot)
//   io_busy              : a boot or soft sequence is in progress
//   io_done              : one-cycle pulse on the edge that enters IDLE
module clock_group_reset_sequencer
  import clock_group_pkg::*;
#(
  parameter int unsigned N_MEMBERS   = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned LEAD_CYCLES = 2,
  parameter bit          CASCADE     = 1'b0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 io_req_valid,
  input  logic [member_width(N_MEMBERS)-1:0]   io_req_member,
  output logic                                 io_req_ready,
  output logic [N_MEMBERS-1:0]                 out_member_reset,
  output logic [N_MEMBERS-1:0]                 out_member_clock_en,
  output logic                                 io_busy,
  output logic                                 io_done
);

  localparam int unsigned MW    = member_width(N_MEMBERS);
  localparam int unsigned CNT_W = counter_width(HOLD_CYCLES, LEAD_CYCLES);

  localparam logic [MW-1:0]    LAST      = MW'(N_MEMBERS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(LEAD_CYCLES);

  if (!params_ok(N_MEMBERS, HOLD_CYCLES, LEAD_CYCLES)) begin : g_param_check
    $error("clock_group_reset_sequencer: N_MEMBERS, HOLD_CYCLES and LEAD_CYCLES must all be >= 1");
  end

  seq_state_t       state;
  logic [MW-1:0]    cursor;
  logic [MW-1:0]    next_cursor;
  logic             at_last;
  logic             boot_entry;
  logic             req_fire;
  logic             req_in_range;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             expire;

  // When the index width can only express legal members the range check
  // folds to constant true.
  if (N_MEMBERS >= (2 ** MW)) begin : g_range_full
    assign req_in_range = 1'b1;
  end else begin : g_range_check
    assign req_in_range = (io_req_member < MW'(N_MEMBERS));
  end

  assign io_req_ready = (state == IDLE);
  assign req_fire     = io_req_ready && io_req_valid;
  assign at_last      = (cursor == LAST);
  assign next_cursor  = cursor + 1'b1;

  // The only way to sit in BOOT_HOLD with the cursor's clock enable still low
  // is straight out of reset; every later BOOT_HOLD entry sets that enable on
  // the transition edge. This marks the one cycle where the first hold count
  // still has to be loaded.
  assign boot_entry = (state == BOOT_HOLD) && !out_member_clock_en[cursor];

  // Counter loads are issued on the same edge as the state transition they
  // time, so the count is valid in the first cycle of each timed state.
  always_comb begin
    load       = 1'b0;
    load_value = '0;
    case (state)
      BOOT_HOLD: begin
        if (boot_entry) begin
          load       = 1'b1;
          load_value = HOLD_LOAD;
        end else if (expire && !at_last) begin
          load       = 1'b1;
          load_value = LEAD_LOAD;
        end
      end
      BOOT_GAP, SOFT_GAP: begin
        if (expire) begin
          load       = 1'b1;
          load_value = HOLD_LOAD;
        end
      end
      IDLE: begin
        if (req_fire && req_in_range) begin
          load       = 1'b1;
          load_value = HOLD_LOAD;
        end
      end
      SOFT_HOLD: begin
        if (expire && CASCADE && !at_last) begin
          load       = 1'b1;
          load_value = LEAD_LOAD;
        end
      end
      default: begin
        load       = 1'b0;
        load_value = '0;
      end
    endcase
  end

  clock_group_delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .expire     (expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= BOOT_HOLD;
      cursor              <= '0;
      out_member_reset    <= '1;
      out_member_clock_en <= '0;
      io_busy             <= 1'b1;
      io_done             <= 1'b0;
    end else begin
      io_done <= 1'b0;
      case (state)
        BOOT_HOLD: begin
          if (boot_entry) begin
            out_member_clock_en[cursor] <= 1'b1;
          end else if (expire) begin
            out_member_reset[cursor] <= 1'b0;
            if (at_last) begin
              state   <= IDLE;
              io_busy <= 1'b0;
              io_done <= 1'b1;
            end else begin
              state <= BOOT_GAP;
            end
          end
        end
        BOOT_GAP: begin
          if (expire) begin
            cursor                           <= next_cursor;
            out_member_clock_en[next_cursor] <= 1'b1;
            state                            <= BOOT_HOLD;
          end
        end
        IDLE: begin
          // Out-of-range requests are accepted by the handshake and dropped.
          if (req_fire && req_in_range) begin
            cursor  <= io_req_member;
            io_busy <= 1'b1;
            state   <= SOFT_HOLD;
            if (CASCADE) begin
              for (int unsigned i = 0; i < N_MEMBERS; i++) begin
                if (i >= 32'(io_req_member)) begin
                  out_member_reset[i] <= 1'b1;
                end
              end
            end else begin
              out_member_reset[io_req_member] <= 1'b1;
            end
          end
        end
        SOFT_HOLD: begin
          if (expire) begin
            out_member_reset[cursor] <= 1'b0;
            if (!CASCADE || at_last) begin
              state   <= IDLE;
              io_busy <= 1'b0;
              io_done <= 1'b1;
            end else begin
              state <= SOFT_GAP;
            end
          end
        end
        SOFT_GAP: begin
          if (expire) begin
            cursor <= next_cursor;
            state  <= SOFT_HOLD;
          end
        end
        default: begin
          state <= BOOT_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// tb_clock_group_reset_sequencer
// Two sequencer instances share clock and reset:
//   inst0: N=2, HOLD=4, LEAD=2, no cascade
//   inst1: N=3, HOLD=4, LEAD=2, cascade
// The reference model describes each sequence by its start edge, first and
// last affected member, and derives every output from the timing rules
// (member j of a sequence releases at start + j*(HOLD+LEAD) + HOLD).
module tb_clock_group_reset_sequencer;

  localparam int H = 4;
  localparam int L = 2;
  localparam int P = H + L;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       a_req_valid = 1'b0;
  logic [0:0] a_req_member = '0;
  logic       a_ready, a_busy, a_done;
  logic [1:0] a_rst, a_en;

  logic       b_req_valid = 1'b0;
  logic [1:0] b_req_member = '0;
  logic       b_ready, b_busy, b_done;
  logic [2:0] b_rst, b_en;

  always #5 clock = ~clock;

  clock_group_reset_sequencer #(
    .N_MEMBERS   (2),
    .HOLD_CYCLES (H),
    .LEAD_CYCLES (L),
    .CASCADE     (1'b0)
  ) dut_a (
    .clock               (clock),
    .reset               (reset),
    .io_req_valid        (a_req_valid),
    .io_req_member       (a_req_member),
    .io_req_ready        (a_ready),
    .out_member_reset    (a_rst),
    .out_member_clock_en (a_en),
    .io_busy             (a_busy),
    .io_done             (a_done)
  );

  clock_group_reset_sequencer #(
    .N_MEMBERS   (3),
    .HOLD_CYCLES (H),
    .LEAD_CYCLES (L),
    .CASCADE     (1'b1)
  ) dut_b (
    .clock               (clock),
    .reset               (reset),
    .io_req_valid        (b_req_valid),
    .io_req_member       (b_req_member),
    .io_req_ready        (b_ready),
    .out_member_reset    (b_rst),
    .out_member_clock_en (b_en),
    .io_busy             (b_busy),
    .io_done             (b_done)
  );

  int passed = 0;
  int total  = 0;
  int edge_n = 0;   // edges since reset deassertion (E1 = 1); 0 while in reset

  int p_n[2] = '{2, 3};
  int p_c[2] = '{0, 1};

  bit m_boot[2];
  int m_start[2];
  int m_first[2];

  // Output vector layout: {ready, done, busy, en[2:0], rst[2:0]}
  function automatic logic [8:0] obs_vec(int inst);
    if (inst == 0) return {a_ready, a_done, a_busy, 1'b0, a_en, 1'b0, a_rst};
    return {b_ready, b_done, b_busy, b_en, b_rst};
  endfunction

  function automatic logic [8:0] exp_vec(int inst, int e);
    int n, d, first, last, end_d;
    logic [2:0] rst, en;
    logic busy, done;
    n   = p_n[inst];
    rst = '0;
    en  = '0;
    if (m_boot[inst]) begin
      d     = e - 1;
      first = 0;
      last  = n - 1;
    end else begin
      d     = e - m_start[inst];
      first = m_first[inst];
      last  = (p_c[inst] != 0) ? n - 1 : first;
    end
    for (int i = 0; i < n; i++) begin
      en[i]  = m_boot[inst] ? (d >= i * P) : 1'b1;
      rst[i] = (i >= first && i <= last) ? (d < (i - first) * P + H) : 1'b0;
    end
    end_d = (last - first) * P + H;
    busy  = (d < end_d);
    done  = (d == end_d);
    return {~busy, done, busy, en, rst};
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      m_boot[i]  = 1'b1;
      m_start[i] = 1;
      m_first[i] = 0;
    end
  endtask

  // Advance one clock edge and update the model for handshakes taken on it.
  task automatic tick();
    bit acc[2];
    int mem[2];
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      e      = exp_vec(i, edge_n);
      acc[i] = ((i == 0) ? a_req_valid : b_req_valid) && e[8];
      mem[i] = (i == 0) ? int'(a_req_member) : int'(b_req_member);
    end
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && mem[i] < p_n[i]) begin
          m_boot[i]  = 1'b0;
          m_start[i] = edge_n;
          m_first[i] = mem[i];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL reset inst%0d got=%b want=%b", i, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
    end
  endtask

  task automatic test_boot();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL boot inst%0d E%0d got=%b want=%b", i, edge_n, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
    end
    // Boot of the two-member instance ends with reset released on E11.
    total++;
    if (a_rst !== 2'b00 || a_en !== 2'b11)
      $display("FAIL boot_final rst=%b en=%b want rst=00 en=11", a_rst, a_en);
    else passed++;
  endtask

  task automatic test_soft_single();
    a_req_valid  = 1'b1;
    a_req_member = 1'b0;
    tick();
    a_req_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL soft_single inst%0d E%0d got=%b want=%b", i, edge_n, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_cascade();
    b_req_valid  = 1'b1;
    b_req_member = 2'd1;
    tick();
    b_req_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL cascade inst%0d E%0d got=%b want=%b", i, edge_n, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // First request starts a sequence; the following ones arrive while busy.
    a_req_valid  = 1'b1;
    a_req_member = 1'b1;
    b_req_valid  = 1'b1;
    b_req_member = 2'd2;
    tick();
    a_req_member = 1'b0;
    b_req_member = 2'd0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL busy_req inst%0d E%0d got=%b want=%b", i, edge_n, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
      tick();
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_out_of_range();
    b_req_valid  = 1'b1;
    b_req_member = 2'd3;
    tick();
    b_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_vec(1) !== exp_vec(1, edge_n))
        $display("FAIL out_of_range E%0d got=%b want=%b", edge_n, obs_vec(1), exp_vec(1, edge_n));
      else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      a_req_valid  = ($urandom_range(0, 3) == 0);
      a_req_member = 1'($urandom_range(0, 1));
      b_req_valid  = ($urandom_range(0, 3) == 0);
      b_req_member = 2'($urandom_range(0, 3));
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL random inst%0d E%0d got=%b want=%b", i, edge_n, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
  endtask

  task automatic test_reset_mid_boot();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    // Between edges after E6: the reset must act without a clock edge.
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs_vec(i) !== exp_vec(i, edge_n))
        $display("FAIL async_reset inst%0d got=%b want=%b", i, obs_vec(i), exp_vec(i, edge_n));
      else passed++;
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i, edge_n))
          $display("FAIL reboot inst%0d E%0d got=%b want=%b", i, edge_n, obs_vec(i), exp_vec(i, edge_n));
        else passed++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_boot();
    test_soft_single();
    test_cascade();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_boot();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
